// File: rtl/rob_rollback_walker_if.sv
// Signal bundle between the recovery controller / ROB and the rollback walker.
// The controller side uses the master modport, the walker uses slave.
interface rob_rollback_walker_if #(
    parameter int TAG_W  = 5,
    parameter int PREG_W = 6
);
    // Handshake: recovery_start is a one-cycle pulse accepted only while the walker
    // is idle. The walker then waits (no outputs) until recovery_rollback is high,
    // walks the squashed entries youngest-first, and pulses ROB_recovery_finished
    // together with rob_tail_update on its last walk cycle. There is no
    // backpressure: every walk cycle's flush/restore/return outputs are consumed.
    logic              recovery_start;
    logic              recovery_rollback;
    logic [TAG_W-1:0]  miss_rob_tag;
    logic              miss_inclusive;
    logic [TAG_W-1:0]  rob_tail;
    logic              rob_full;

    logic [TAG_W-1:0]  rd_idx_0;
    logic [TAG_W-1:0]  rd_idx_1;
    logic              rd_has_dest_0;
    logic              rd_has_dest_1;
    logic [4:0]        rd_areg_0;
    logic [4:0]        rd_areg_1;
    logic [PREG_W-1:0] rd_old_preg_0;
    logic [PREG_W-1:0] rd_old_preg_1;
    logic [PREG_W-1:0] rd_new_preg_0;
    logic [PREG_W-1:0] rd_new_preg_1;

    logic [TAG_W-1:0]  flush_rob_tag_0;
    logic [TAG_W-1:0]  flush_rob_tag_1;
    logic              flush_rob_tag_0_valid;
    logic              flush_rob_tag_1_valid;

    logic              rn_restore_valid_0;
    logic              rn_restore_valid_1;
    logic [4:0]        rn_restore_areg_0;
    logic [4:0]        rn_restore_areg_1;
    logic [PREG_W-1:0] rn_restore_preg_0;
    logic [PREG_W-1:0] rn_restore_preg_1;

    logic              fl_return_valid_0;
    logic              fl_return_valid_1;
    logic [PREG_W-1:0] fl_return_preg_0;
    logic [PREG_W-1:0] fl_return_preg_1;

    logic              rob_tail_update;
    logic [TAG_W-1:0]  rob_new_tail;
    logic              ROB_recovery_finished;
    logic [1:0]        walk_state;

    modport master (
        output recovery_start, recovery_rollback, miss_rob_tag, miss_inclusive,
               rob_tail, rob_full,
               rd_has_dest_0, rd_has_dest_1, rd_areg_0, rd_areg_1,
               rd_old_preg_0, rd_old_preg_1, rd_new_preg_0, rd_new_preg_1,
        input  rd_idx_0, rd_idx_1,
               flush_rob_tag_0, flush_rob_tag_1, flush_rob_tag_0_valid, flush_rob_tag_1_valid,
               rn_restore_valid_0, rn_restore_valid_1, rn_restore_areg_0, rn_restore_areg_1,
               rn_restore_preg_0, rn_restore_preg_1,
               fl_return_valid_0, fl_return_valid_1, fl_return_preg_0, fl_return_preg_1,
               rob_tail_update, rob_new_tail, ROB_recovery_finished, walk_state
    );

    modport slave (
        input  recovery_start, recovery_rollback, miss_rob_tag, miss_inclusive,
               rob_tail, rob_full,
               rd_has_dest_0, rd_has_dest_1, rd_areg_0, rd_areg_1,
               rd_old_preg_0, rd_old_preg_1, rd_new_preg_0, rd_new_preg_1,
        output rd_idx_0, rd_idx_1,
               flush_rob_tag_0, flush_rob_tag_1, flush_rob_tag_0_valid, flush_rob_tag_1_valid,
               rn_restore_valid_0, rn_restore_valid_1, rn_restore_areg_0, rn_restore_areg_1,
               rn_restore_preg_0, rn_restore_preg_1,
               fl_return_valid_0, fl_return_valid_1, fl_return_preg_0, fl_return_preg_1,
               rob_tail_update, rob_new_tail, ROB_recovery_finished, walk_state
    );
endinterface

// File: rtl/rob_rollback_walker.sv
// Walks squashed ROB entries youngest-first, two per cycle, restoring rename
// mappings and returning physical registers, then rewinds the ROB tail.
module rob_rollback_walker #(
    parameter int ROB_DEPTH = 32,
    parameter int TAG_W     = 5,
    parameter int PREG_W    = 6
) (
    input logic                  clk,
    input logic                  rst,
    rob_rollback_walker_if.slave bus
);
    localparam int CNT_W = TAG_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_WALK  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [TAG_W-1:0]  first;
    logic [TAG_W-1:0]  ptr;
    logic [CNT_W-1:0]  count;

    logic [TAG_W-1:0]  first_cap;
    logic [CNT_W-1:0]  count_cap;
    logic [TAG_W-1:0]  tag_0;
    logic [TAG_W-1:0]  tag_1;
    logic [CNT_W-1:0]  step_n;
    logic              walking;
    logic              last_step;
    logic              slot_0_use;
    logic              slot_1_use;
    logic              restore_0;
    logic              restore_1;
    logic [PREG_W-1:0] old_preg_0;
    logic [PREG_W-1:0] old_preg_1;
    logic [PREG_W-1:0] new_preg_0;
    logic [PREG_W-1:0] new_preg_1;

    // A full ROB with tail == first means every entry is squashed, not none.
    always_comb begin
        first_cap = bus.miss_rob_tag + (bus.miss_inclusive ? TAG_W'(0) : TAG_W'(1));
        count_cap = {1'b0, bus.rob_tail - first_cap};
        if (bus.rob_full && (bus.rob_tail == first_cap)) begin
            count_cap = CNT_W'(ROB_DEPTH);
        end
    end

    assign walking    = (state == S_WALK);
    assign slot_0_use = walking && (count != '0);
    assign slot_1_use = walking && (count >= CNT_W'(2));
    assign last_step  = walking && (count <= CNT_W'(2));
    assign step_n     = slot_1_use ? CNT_W'(2) : (slot_0_use ? CNT_W'(1) : '0);
    assign tag_0      = ptr - TAG_W'(1);
    assign tag_1      = ptr - TAG_W'(2);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.recovery_start)    state_nx = S_ARMED;
            S_ARMED: if (bus.recovery_rollback) state_nx = S_WALK;
            S_WALK:  if (last_step)             state_nx = S_IDLE;
            default:                            state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            first <= '0;
            ptr   <= '0;
            count <= '0;
        end else begin
            state <= state_nx;
            if ((state == S_IDLE) && bus.recovery_start) begin
                first <= first_cap;
                ptr   <= bus.rob_tail;
                count <= count_cap;
            end else if (walking) begin
                ptr   <= ptr - step_n[TAG_W-1:0];
                count <= count - step_n;
            end
        end
    end

    assign restore_0  = slot_0_use && bus.rd_has_dest_0;
    assign restore_1  = slot_1_use && bus.rd_has_dest_1;
    assign old_preg_0 = restore_0 ? bus.rd_old_preg_0 : '0;
    assign old_preg_1 = restore_1 ? bus.rd_old_preg_1 : '0;
    assign new_preg_0 = restore_0 ? bus.rd_new_preg_0 : '0;
    assign new_preg_1 = restore_1 ? bus.rd_new_preg_1 : '0;

    // Everything is gated by state, so async reset zeroes outputs immediately.
    assign bus.rd_idx_0              = walking ? tag_0 : '0;
    assign bus.rd_idx_1              = walking ? tag_1 : '0;
    assign bus.flush_rob_tag_0       = slot_0_use ? tag_0 : '0;
    assign bus.flush_rob_tag_1       = slot_1_use ? tag_1 : '0;
    assign bus.flush_rob_tag_0_valid = slot_0_use;
    assign bus.flush_rob_tag_1_valid = slot_1_use;

    // Slot 1 is older; downstream applies it after slot 0 so its old mapping wins.
    assign bus.rn_restore_valid_0    = restore_0;
    assign bus.rn_restore_valid_1    = restore_1;
    assign bus.rn_restore_areg_0     = restore_0 ? bus.rd_areg_0 : '0;
    assign bus.rn_restore_areg_1     = restore_1 ? bus.rd_areg_1 : '0;
    assign bus.rn_restore_preg_0     = old_preg_0;
    assign bus.rn_restore_preg_1     = old_preg_1;

    assign bus.fl_return_valid_0     = restore_0;
    assign bus.fl_return_valid_1     = restore_1;
    assign bus.fl_return_preg_0      = new_preg_0;
    assign bus.fl_return_preg_1      = new_preg_1;

    assign bus.rob_tail_update       = last_step;
    assign bus.rob_new_tail          = last_step ? first : '0;
    assign bus.ROB_recovery_finished = last_step;
    assign bus.walk_state            = state;
endmodule

// File: tb/tb_rob_rollback_walker.sv
// Bench for rob_rollback_walker: table of recovery scenarios checked against a
// queue of expected flushed tags, plus reset-mid-walk and same-areg sequences.
module tb_rob_rollback_walker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rob_rollback_walker_if #(.TAG_W(5), .PREG_W(6)) bus ();

    rob_rollback_walker #(.ROB_DEPTH(32), .TAG_W(5), .PREG_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ROB contents model answering the walker's read ports
    logic       rob_has  [32];
    logic [4:0] rob_areg [32];
    logic [5:0] rob_old  [32];
    logic [5:0] rob_new  [32];

    always_comb begin
        bus.rd_has_dest_0 = rob_has[bus.rd_idx_0];
        bus.rd_has_dest_1 = rob_has[bus.rd_idx_1];
        bus.rd_areg_0     = rob_areg[bus.rd_idx_0];
        bus.rd_areg_1     = rob_areg[bus.rd_idx_1];
        bus.rd_old_preg_0 = rob_old[bus.rd_idx_0];
        bus.rd_old_preg_1 = rob_old[bus.rd_idx_1];
        bus.rd_new_preg_0 = rob_new[bus.rd_idx_0];
        bus.rd_new_preg_1 = rob_new[bus.rd_idx_1];
    end

    typedef struct {
        logic [4:0] tail;
        logic [4:0] miss;
        logic       incl;
        logic       full;
        logic [4:0] exp_first;
        int         exp_count;
    } vec_t;

    vec_t       vecs [7];
    logic [4:0] exp_q [$];
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_flush_v0"}, 32'(bus.flush_rob_tag_0_valid), 0);
        check({name, "_flush_v1"}, 32'(bus.flush_rob_tag_1_valid), 0);
        check({name, "_rn_v"}, 32'(bus.rn_restore_valid_0 | bus.rn_restore_valid_1), 0);
        check({name, "_fl_v"}, 32'(bus.fl_return_valid_0 | bus.fl_return_valid_1), 0);
        check({name, "_finished"}, 32'(bus.ROB_recovery_finished | bus.rob_tail_update), 0);
    endtask

    task automatic check_slot(input string nm, input logic fv, input logic [4:0] ft,
                              input logic rv, input logic [4:0] ra, input logic [5:0] rp,
                              input logic lv, input logic [5:0] lp);
        logic [4:0] t;
        if (exp_q.size() > 0) begin
            t = exp_q.pop_front();
            check({nm, "_flush_v"}, 32'(fv), 1);
            check({nm, "_flush_tag"}, 32'(ft), 32'(t));
            check({nm, "_rn_v"}, 32'(rv), 32'(rob_has[t]));
            check({nm, "_fl_v"}, 32'(lv), 32'(rob_has[t]));
            if (rob_has[t]) begin
                check({nm, "_rn_areg"}, 32'(ra), 32'(rob_areg[t]));
                check({nm, "_rn_preg"}, 32'(rp), 32'(rob_old[t]));
                check({nm, "_fl_preg"}, 32'(lp), 32'(rob_new[t]));
            end
        end else begin
            check({nm, "_flush_v_unused"}, 32'(fv), 0);
            check({nm, "_rn_v_unused"}, 32'(rv), 0);
            check({nm, "_fl_v_unused"}, 32'(lv), 0);
        end
    endtask

    // Issue a recovery and leave the walker in ARMED with the expected tags queued.
    task automatic start_recovery(input logic [4:0] tail, input logic [4:0] miss,
                                  input logic incl, input logic full, input int cnt);
        @(negedge clk);
        bus.recovery_start    = 1'b1;
        bus.recovery_rollback = 1'b0;
        bus.rob_tail          = tail;
        bus.miss_rob_tag      = miss;
        bus.miss_inclusive    = incl;
        bus.rob_full          = full;
        exp_q.delete();
        for (int k = 1; k <= cnt; k++) exp_q.push_back(tail - 5'(k));
        @(negedge clk);
        check("armed_state", 32'(bus.walk_state), 1);
        check_idle_outputs("armed");
        // a second start while busy must be ignored
        bus.recovery_start = 1'b1;
        bus.miss_rob_tag   = miss ^ 5'd9;
        bus.rob_tail       = tail ^ 5'd3;
        @(negedge clk);
        bus.recovery_start = 1'b0;
        check("armed_hold", 32'(bus.walk_state), 1);
        bus.recovery_rollback = 1'b1;
    endtask

    task automatic run_case(input logic [4:0] tail, input logic [4:0] miss, input logic incl,
                            input logic full, input logic [4:0] exp_first, input int cnt);
        int  cycles;
        bit  done;
        int  exp_cycles;
        exp_cycles = (cnt == 0) ? 1 : (cnt + 1) / 2;
        start_recovery(tail, miss, incl, full, cnt);
        cycles = 0;
        done   = 1'b0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
            check("walk_state", 32'(bus.walk_state), 2);
            check_slot("slot0", bus.flush_rob_tag_0_valid, bus.flush_rob_tag_0,
                       bus.rn_restore_valid_0, bus.rn_restore_areg_0, bus.rn_restore_preg_0,
                       bus.fl_return_valid_0, bus.fl_return_preg_0);
            check_slot("slot1", bus.flush_rob_tag_1_valid, bus.flush_rob_tag_1,
                       bus.rn_restore_valid_1, bus.rn_restore_areg_1, bus.rn_restore_preg_1,
                       bus.fl_return_valid_1, bus.fl_return_preg_1);
            if (bus.ROB_recovery_finished) begin
                done = 1'b1;
                check("tail_update", 32'(bus.rob_tail_update), 1);
                check("new_tail", 32'(bus.rob_new_tail), 32'(exp_first));
                bus.recovery_rollback = 1'b0;
            end
        end
        check("walk_done_in_budget", 32'(done), 1);
        check("walk_cycles", 32'(cycles), 32'(exp_cycles));
        check("queue_drained", 32'(exp_q.size()), 0);
        bus.recovery_rollback = 1'b0;
        @(negedge clk);
        check("back_idle", 32'(bus.walk_state), 0);
        check_idle_outputs("post");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rob_has[i]  = (i % 3) != 0;
            rob_areg[i] = 5'(i * 7);
            rob_old[i]  = 6'(i);
            rob_new[i]  = 6'(i + 32);
        end
        vecs[0] = '{tail: 5'd10, miss: 5'd4,  incl: 1'b0, full: 1'b0, exp_first: 5'd5,  exp_count: 5};
        vecs[1] = '{tail: 5'd2,  miss: 5'd29, incl: 1'b1, full: 1'b0, exp_first: 5'd29, exp_count: 5};
        vecs[2] = '{tail: 5'd7,  miss: 5'd6,  incl: 1'b0, full: 1'b0, exp_first: 5'd7,  exp_count: 0};
        vecs[3] = '{tail: 5'd12, miss: 5'd11, incl: 1'b0, full: 1'b1, exp_first: 5'd12, exp_count: 32};
        vecs[4] = '{tail: 5'd20, miss: 5'd19, incl: 1'b1, full: 1'b0, exp_first: 5'd19, exp_count: 1};
        vecs[5] = '{tail: 5'd0,  miss: 5'd31, incl: 1'b0, full: 1'b0, exp_first: 5'd0,  exp_count: 0};
        vecs[6] = '{tail: 5'd3,  miss: 5'd30, incl: 1'b0, full: 1'b0, exp_first: 5'd31, exp_count: 4};

        bus.recovery_start    = 1'b0;
        bus.recovery_rollback = 1'b0;
        bus.miss_rob_tag      = '0;
        bus.miss_inclusive    = 1'b0;
        bus.rob_tail          = '0;
        bus.rob_full          = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_state", 32'(bus.walk_state), 0);
        check_idle_outputs("reset");
        check("reset_new_tail", 32'(bus.rob_new_tail), 0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_case(vecs[v].tail, vecs[v].miss, vecs[v].incl, vecs[v].full,
                     vecs[v].exp_first, vecs[v].exp_count);
        end

        // Same areg in both slots: slot0 (tag 9) restores 40, older slot1 (tag 8) restores 41
        rob_has[9] = 1'b1; rob_areg[9] = 5'd3; rob_old[9] = 6'd40; rob_new[9] = 6'd50;
        rob_has[8] = 1'b1; rob_areg[8] = 5'd3; rob_old[8] = 6'd41; rob_new[8] = 6'd51;
        start_recovery(5'd10, 5'd7, 1'b0, 1'b0, 2);
        @(negedge clk);
        check("same_areg_rn0", 32'(bus.rn_restore_preg_0), 40);
        check("same_areg_rn1", 32'(bus.rn_restore_preg_1), 41);
        check("same_areg_a0", 32'(bus.rn_restore_areg_0), 3);
        check("same_areg_a1", 32'(bus.rn_restore_areg_1), 3);
        check("same_areg_fl0", 32'(bus.fl_return_preg_0), 50);
        check("same_areg_fl1", 32'(bus.fl_return_preg_1), 51);
        check("same_areg_fin", 32'(bus.ROB_recovery_finished), 1);
        check("same_areg_tail", 32'(bus.rob_new_tail), 8);
        bus.recovery_rollback = 1'b0;
        @(negedge clk);
        check("same_areg_idle", 32'(bus.walk_state), 0);

        // Reset asserted during the second walk cycle
        start_recovery(5'd10, 5'd4, 1'b0, 1'b0, 5);
        @(negedge clk);
        check("rst_walk1_tag", 32'(bus.flush_rob_tag_0), 9);
        @(posedge clk);
        #2;
        check("rst_walk2_valid", 32'(bus.flush_rob_tag_0_valid), 1);
        check("rst_walk2_tag", 32'(bus.flush_rob_tag_0), 7);
        rst = 1'b1;
        #1;
        check("rst_mid_state", 32'(bus.walk_state), 0);
        check_idle_outputs("rst_mid");
        check("rst_mid_idx", 32'(bus.rd_idx_0), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.recovery_rollback = 1'b0;
        exp_q.delete();
        run_case(5'd10, 5'd4, 1'b0, 1'b0, 5'd5, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rob_rollback_walker.md
ROB_ROLLBACK_WALKER -- requirements
Module: rob_rollback_walker

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 32, number of ROB entries (power of two).
REQ-002 SHALL have parameter TAG_W, default 5, ROB tag width = log2(ROB_DEPTH).
REQ-003 SHALL have parameter PREG_W, default 6, physical register index width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port recovery_start  in  1  pulse: branch mispredict or store-set violation detected this cycle.
REQ-007 SHALL have port recovery_rollback  in  1  controller is in rollback phase.
REQ-008 SHALL have port miss_rob_tag  in  TAG_W  ROB tag of mispredicted branch or violating load.
REQ-009 SHALL have port miss_inclusive  in  1  1 = flush miss_rob_tag itself (store-set violation); 0 = keep it (branch).
REQ-010 SHALL have ports rob_tail  in  TAG_W  next-allocate pointer; rob_full  in  1  ROB full.
REQ-011 SHALL have ports rd_idx_0 / rd_idx_1  out  TAG_W  combinational ROB read addresses.
REQ-012 SHALL have ports rd_has_dest_0/1  in  1, rd_areg_0/1  in  5, rd_old_preg_0/1  in  PREG_W, rd_new_preg_0/1  in  PREG_W  same-cycle ROB read data.
REQ-013 SHALL have ports flush_rob_tag_0/1  out  TAG_W, flush_rob_tag_0_valid/1_valid  out  1  per-cycle flushed entries.
REQ-014 SHALL have ports rn_restore_valid_0/1  out  1, rn_restore_areg_0/1  out  5, rn_restore_preg_0/1  out  PREG_W  rename-table restore.
REQ-015 SHALL have ports fl_return_valid_0/1  out  1, fl_return_preg_0/1  out  PREG_W  freelist return.
REQ-016 SHALL have ports rob_tail_update  out  1, rob_new_tail  out  TAG_W, ROB_recovery_finished  out  1.

Function
REQ-017 SHALL implement FSM IDLE, ARMED, WALK.
REQ-018 IDLE: on recovery_start SHALL capture first = miss_rob_tag + (miss_inclusive ? 0 : 1) mod ROB_DEPTH, ptr = rob_tail, count = (rob_tail - first) mod ROB_DEPTH, or ROB_DEPTH when rob_full and rob_tail == first; go ARMED.
REQ-019 count SHALL be TAG_W+1 bits wide.
REQ-020 ARMED (controller flush cycle): no outputs active; go WALK when recovery_rollback=1, else hold.
REQ-021 WALK: each cycle SHALL process n = min(count, 2) entries, youngest first: slot 0 = ptr-1, slot 1 = ptr-2 (mod ROB_DEPTH); rd_idx_0/1 driven with these.
REQ-022 For each processed slot: flush_rob_tag valid=1; rn_restore and fl_return valid = rd_has_dest of that slot.
REQ-023 Unused slot (n<2) SHALL drive all its valids 0.
REQ-024 Downstream applies slot 0 then slot 1; on equal areg, slot 1 (older) old_preg SHALL be final.
REQ-025 WALK SHALL update ptr -= n, count -= n.
REQ-026 When count <= 2 in WALK: ROB_recovery_finished=1, rob_tail_update=1, rob_new_tail=first, same cycle; next state IDLE.
REQ-027 count=0 SHALL produce finished in first WALK cycle with no slot valids.
REQ-028 Walk latency SHALL be max(1, ceil(count/2)) WALK cycles.
REQ-029 recovery_start outside IDLE SHALL be ignored.
REQ-030 rd_idx_0/1 outside WALK SHALL be don't-care; all valids and finished SHALL be 0 outside WALK.

Reset
REQ-031 rst SHALL immediately force IDLE, ptr/first/count 0, all outputs 0, including mid-WALK.

Verification
REQ-032 tail=10, miss=4, incl=0 -> first=5, count=5; WALK tags (9,8),(7,6),(5,-); finished+new_tail=5 in 3rd cycle.
REQ-033 tail=2, miss=29, incl=1 -> wrap; count=5; tags (1,0),(31,30),(29,-).
REQ-034 tail=7, miss=6, incl=0 -> count=0; finished in first WALK cycle, no valids, new_tail=7.
REQ-035 rob_full, tail=12, miss=11, incl=0 -> count=32; 16 WALK cycles, finished on 16th.
REQ-036 slots both has_dest, areg=3, old_preg 40/41 -> restore outputs 40 (slot0), 41 (slot1); fl_return new_preg both.
REQ-037 rst asserted during 2nd WALK cycle -> outputs 0 same cycle; later recovery_start processed normally.
